stack_unit: RTL and testbench

- Parametrised successor to the fixed-width evaluation stack used by the calculator CPU for its data and operator stacks.
- Adds:
  - configurable depth;
  - a valid/ready command handshake;
  - direct top/next-of-stack read ports that feed the ALU;
  - a combined pop-two-push-one operation for binary-operator results;
  - sticky overflow/underflow error reporting.
- The CPU instantiates two copies: data stack (DW = data width) and operator stack (DW = operator code width).

---
 rtl/stack_unit_pkg.sv | 19 +
 rtl/stack_mem.sv | 63 ++++++
 rtl/stack_unit.sv | 143 ++++++++++++++
 tb/tb_stack_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_unit_pkg.sv
// Shared command and error encodings for the evaluation stack and the CPU sequencer.
package stack_unit_pkg;

  // Command field width
  localparam int unsigned SC_N = 3;

  localparam logic [SC_N-1:0] SC_NOP      = 3'd0;
  localparam logic [SC_N-1:0] SC_PUSH     = 3'd1;
  localparam logic [SC_N-1:0] SC_POP      = 3'd2;
  localparam logic [SC_N-1:0] SC_REPL     = 3'd3;
  localparam logic [SC_N-1:0] SC_POP2PUSH = 3'd4;
  localparam logic [SC_N-1:0] SC_CLEAR    = 3'd5;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

endpackage

// File: rtl/stack_mem.sv
// DEPTH x DW register array with one write port and registered top/next read addresses.
// Read addresses are captured from the next-state occupancy, so the outputs reflect the
// stack right after the accepting edge with no exposed read latency.
module stack_mem #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [CW-1:0] count_nxt,
  output logic [DW-1:0] rd_top,
  output logic [DW-1:0] rd_next
);

  logic [DW-1:0] mem_q [DEPTH];

  logic [AW-1:0] top_addr_d, top_addr_q;
  logic [AW-1:0] next_addr_d, next_addr_q;
  logic          top_vld_d, top_vld_q;
  logic          next_vld_d, next_vld_q;

  // Storage write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Next read addresses and validity from the post-command occupancy
  always_comb begin
    top_addr_d  = AW'(count_nxt - CW'(1));
    next_addr_d = AW'(count_nxt - CW'(2));
    top_vld_d   = (count_nxt >= CW'(1));
    next_vld_d  = (count_nxt >= CW'(2));
  end

  // Read address registers; validity clears on reset so both ports read as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_addr_q  <= '0;
      next_addr_q <= '0;
      top_vld_q   <= 1'b0;
      next_vld_q  <= 1'b0;
    end else begin
      top_addr_q  <= top_addr_d;
      next_addr_q <= next_addr_d;
      top_vld_q   <= top_vld_d;
      next_vld_q  <= next_vld_d;
    end
  end

  // Masked reads: an invalid slot (wrapped address) reads as zero
  always_comb begin
    rd_top  = top_vld_q ? mem_q[top_addr_q] : '0;
    rd_next = next_vld_q ? mem_q[next_addr_q] : '0;
  end

endmodule

// File: rtl/stack_unit.sv
// Parametrised evaluation stack with valid/ready commands, top/next read ports,
// pop-two-push-one for binary-operator results and sticky error reporting.
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter int unsigned DW          = 16,
  parameter int unsigned DEPTH       = 16,
  parameter bit          HOLD_ON_ERR = 1'b1,
  localparam int unsigned CW         = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [SC_N-1:0] cmd,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   top,
  output logic [DW-1:0]   next,
  output logic [CW-1:0]   count,
  output logic            empty,
  output logic            full,
  output logic            err,
  output logic [1:0]      err_code
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [CW-1:0] count_d, count_q;
  logic          err_d, err_q;
  logic [1:0]    code_d, code_q;

  logic          accept;
  logic          fail;
  logic [1:0]    fail_code;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  assign cmd_ready = !(HOLD_ON_ERR && err_q);

  // Command decode: occupancy update, storage write and error capture
  always_comb begin
    // CLEAR bypasses the ready gate so a held unit can always be recovered
    accept    = cmd_valid && (cmd_ready || (cmd == SC_CLEAR));
    count_d   = count_q;
    err_d     = err_q;
    code_d    = code_q;
    fail      = 1'b0;
    fail_code = ERR_NONE;
    wr_en     = 1'b0;
    wr_addr   = '0;
    if (accept) begin
      case (cmd)
        SC_NOP: ;
        SC_PUSH: begin
          if (count_q != CW'(DEPTH)) begin
            wr_en   = 1'b1;
            wr_addr = AW'(count_q);
            count_d = count_q + CW'(1);
          end else begin
            fail      = 1'b1;
            fail_code = ERR_OVERFLOW;
          end
        end
        SC_POP: begin
          if (count_q != '0) begin
            count_d = count_q - CW'(1);
          end else begin
            fail      = 1'b1;
            fail_code = ERR_UNDERFLOW;
          end
        end
        SC_REPL: begin
          if (count_q != '0) begin
            wr_en   = 1'b1;
            wr_addr = AW'(count_q - CW'(1));
          end else begin
            fail      = 1'b1;
            fail_code = ERR_UNDERFLOW;
          end
        end
        SC_POP2PUSH: begin
          // Result lands in the old next slot, which becomes the new top
          if (count_q >= CW'(2)) begin
            wr_en   = 1'b1;
            wr_addr = AW'(count_q - CW'(2));
            count_d = count_q - CW'(1);
          end else begin
            fail      = 1'b1;
            fail_code = ERR_UNDERFLOW;
          end
        end
        SC_CLEAR: begin
          count_d = '0;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
        end
        default: begin
          fail      = 1'b1;
          fail_code = ERR_ILLEGAL;
        end
      endcase
    end
    // First error wins; later ones leave the latched code alone
    if (fail && !err_q) begin
      err_d  = 1'b1;
      code_d = fail_code;
    end
  end

  // Occupancy and error state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  stack_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (wr_en),
    .waddr     (wr_addr),
    .wdata     (wdata),
    .count_nxt (count_d),
    .rd_top    (top),
    .rd_next   (next)
  );

  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign err      = err_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench: two DEPTH=4 stacks (HOLD_ON_ERR=1 and 0) share one stimulus stream
// and are compared against an array-based reference model after every clock.
module tb_stack_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [15:0] wdata;

  logic [15:0] top0, next0, top1, next1;
  logic [2:0]  cnt0, cnt1;
  logic        emp0, full0, err0, rdy0, emp1, full1, err1, rdy1;
  logic [1:0]  code0, code1;

  logic [15:0] top_a [2];
  logic [15:0] next_a [2];
  logic [2:0]  cnt_a [2];
  logic        emp_a [2];
  logic        full_a [2];
  logic        err_a [2];
  logic        rdy_a [2];
  logic [1:0]  code_a [2];

  assign top_a[0] = top0;   assign top_a[1] = top1;
  assign next_a[0] = next0; assign next_a[1] = next1;
  assign cnt_a[0] = cnt0;   assign cnt_a[1] = cnt1;
  assign emp_a[0] = emp0;   assign emp_a[1] = emp1;
  assign full_a[0] = full0; assign full_a[1] = full1;
  assign err_a[0] = err0;   assign err_a[1] = err1;
  assign rdy_a[0] = rdy0;   assign rdy_a[1] = rdy1;
  assign code_a[0] = code0; assign code_a[1] = code1;

  stack_unit #(.DW(16), .DEPTH(4), .HOLD_ON_ERR(1'b1)) u_hold (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy0), .cmd(cmd),
    .wdata(wdata), .top(top0), .next(next0), .count(cnt0), .empty(emp0), .full(full0),
    .err(err0), .err_code(code0)
  );

  stack_unit #(.DW(16), .DEPTH(4), .HOLD_ON_ERR(1'b0)) u_run (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy1), .cmd(cmd),
    .wdata(wdata), .top(top1), .next(next1), .count(cnt1), .empty(emp1), .full(full1),
    .err(err1), .err_code(code1)
  );

  always #5 clk = ~clk;

  // Reference model: plain array stack per instance
  localparam int MDEPTH = 4;
  bit          mhold [2] = '{1'b1, 1'b0};
  logic [15:0] mstk [2][MDEPTH];
  int          mcnt [2];
  bit          merr [2];
  int          mcode [2];

  int checks = 0;
  int failures = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0;
      merr[i] = 1'b0;
      mcode[i] = 0;
    end
  endtask

  task automatic model_fail(int i, int code);
    if (!merr[i]) begin
      merr[i] = 1'b1;
      mcode[i] = code;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit rdy;
      rdy = !(mhold[i] && merr[i]);
      if (cmd_valid && (rdy || cmd == 3'd5)) begin
        case (int'(cmd))
          0: ;
          1: if (mcnt[i] < MDEPTH) begin mstk[i][mcnt[i]] = wdata; mcnt[i]++; end
             else model_fail(i, 1);
          2: if (mcnt[i] >= 1) mcnt[i]--; else model_fail(i, 2);
          3: if (mcnt[i] >= 1) mstk[i][mcnt[i]-1] = wdata; else model_fail(i, 2);
          4: if (mcnt[i] >= 2) begin mcnt[i]--; mstk[i][mcnt[i]-1] = wdata; end
             else model_fail(i, 2);
          5: begin mcnt[i] = 0; merr[i] = 1'b0; mcode[i] = 0; end
          default: model_fail(i, 3);
        endcase
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int i = 0; i < 2; i++) begin
      logic [15:0] et, en;
      et = (mcnt[i] >= 1) ? mstk[i][mcnt[i]-1] : 16'h0;
      en = (mcnt[i] >= 2) ? mstk[i][mcnt[i]-2] : 16'h0;
      chk($sformatf("%s.%0d.top", tag, i), 32'(top_a[i]), 32'(et));
      chk($sformatf("%s.%0d.next", tag, i), 32'(next_a[i]), 32'(en));
      chk($sformatf("%s.%0d.count", tag, i), 32'(cnt_a[i]), 32'(mcnt[i]));
      chk($sformatf("%s.%0d.empty", tag, i), 32'(emp_a[i]), 32'(mcnt[i] == 0));
      chk($sformatf("%s.%0d.full", tag, i), 32'(full_a[i]), 32'(mcnt[i] == MDEPTH));
      chk($sformatf("%s.%0d.err", tag, i), 32'(err_a[i]), 32'(merr[i]));
      chk($sformatf("%s.%0d.code", tag, i), 32'(code_a[i]), 32'(mcode[i]));
      chk($sformatf("%s.%0d.ready", tag, i), 32'(rdy_a[i]), 32'(!(mhold[i] && merr[i])));
    end
  endtask

  // One command offered for exactly one rising edge, then withdrawn
  task automatic do_cmd(logic [2:0] c, logic [15:0] wd, string tag);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd = c;
    wdata = wd;
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
    cmd_valid = 1'b0;
  endtask

  task automatic rand_step(int n);
    int r;
    @(negedge clk);
    cmd_valid = ($urandom_range(0, 3) != 0);
    r = $urandom_range(0, 15);
    if (r <= 4) cmd = 3'd1;
    else if (r <= 7) cmd = 3'd2;
    else if (r <= 9) cmd = 3'd3;
    else if (r <= 11) cmd = 3'd4;
    else if (r <= 13) cmd = 3'd5;
    else if (r == 14) cmd = 3'd0;
    else cmd = 3'(6 + $urandom_range(0, 1));
    wdata = 16'($urandom);
    @(posedge clk);
    #1;
    model_step();
    check_all($sformatf("rand%0d", n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd = 3'd0;
    wdata = 16'h0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic pushes
    do_cmd(3'd1, 16'h0011, "push1");
    do_cmd(3'd1, 16'h0022, "push2");
    do_cmd(3'd1, 16'h0033, "push3");
    chk("tp1.top", 32'(top0), 32'h0033);
    chk("tp1.next", 32'(next0), 32'h0022);
    chk("tp1.count", 32'(cnt0), 32'd3);

    // Binary-op result then replace
    do_cmd(3'd4, 16'h0055, "p2p");
    chk("tp2.top", 32'(top0), 32'h0055);
    chk("tp2.next", 32'(next0), 32'h0011);
    do_cmd(3'd3, 16'h0077, "repl");
    chk("tp2.repl", 32'(top0), 32'h0077);

    // Overflow at DEPTH=4
    do_cmd(3'd5, 16'h0, "clr0");
    for (int k = 0; k < 5; k++) do_cmd(3'd1, 16'(16'h0100 + k), $sformatf("fill%0d", k));
    chk("tp3.full", 32'(full0), 32'd1);
    chk("tp3.top", 32'(top0), 32'h0103);
    chk("tp3.code", 32'(code0), 32'd1);
    chk("tp3.ready_hold", 32'(rdy0), 32'd0);
    chk("tp3.ready_run", 32'(rdy1), 32'd1);
    // Held unit still accepts REPL? no: gated; run unit replaces at full
    do_cmd(3'd3, 16'h0BEE, "repl_full");
    do_cmd(3'd5, 16'h0, "clr1");
    chk("tp3.clr_ready", 32'(rdy0), 32'd1);

    // Underflow, then keep running on the non-holding unit
    do_cmd(3'd2, 16'h0, "pop_empty");
    chk("tp4.code", 32'(code0), 32'd2);
    do_cmd(3'd1, 16'h0044, "push_after_err");
    chk("tp4.run_count", 32'(cnt1), 32'd1);
    chk("tp4.run_code", 32'(code1), 32'd2);
    chk("tp4.hold_count", 32'(cnt0), 32'd0);
    do_cmd(3'd5, 16'h0, "clr2");

    // POP2PUSH underflow with one entry, then reserved command
    do_cmd(3'd1, 16'h0066, "push_one");
    do_cmd(3'd4, 16'h0099, "p2p_short");
    chk("tp5.top", 32'(top0), 32'h0066);
    do_cmd(3'd5, 16'h0, "clr3");
    do_cmd(3'd6, 16'h0, "reserved");
    chk("tp5.code", 32'(code0), 32'd3);
    do_cmd(3'd7, 16'h0, "reserved_again");
    do_cmd(3'd0, 16'h0, "nop");
    do_cmd(3'd5, 16'h0, "clr4");

    // Async reset mid-cycle with a pending command
    do_cmd(3'd1, 16'h0001, "pre_rst1");
    do_cmd(3'd1, 16'h0002, "pre_rst2");
    do_cmd(3'd1, 16'h0003, "pre_rst3");
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd = 3'd1;
    wdata = 16'h00BB;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd(3'd1, 16'h00AA, "post_rst");
    chk("tp6.top", 32'(top0), 32'h00AA);
    chk("tp6.next", 32'(next0), 32'h0000);

    // Randomized run against the model
    for (int n = 0; n < 400; n++) rand_step(n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
